// File: rtl/ex_stage.sv
// MIPS execute stage: logic/shift/move/multiply in one cycle, restoring divider over
// DIV_CYCLES iterations, same-cycle forward to decode and a registered EX/MEM boundary.
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic        ex_wreg_o,
  output logic [4:0]  ex_wd_o,
  output logic [31:0] ex_wdata_o,
  output logic        stall_req_o,
  output logic        mem_wreg_o,
  output logic [4:0]  mem_wd_o,
  output logic [31:0] mem_wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_SLLV  = 8'h04;
  localparam logic [7:0] OP_SRLV  = 8'h06;
  localparam logic [7:0] OP_SRAV  = 8'h07;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;

  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_MOVE  = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // Two's-complement negate when requested; used for magnitudes and sign fix-up.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    cond_neg = neg ? (~v + 32'd1) : v;
  endfunction

  div_state_e state_q, state_d;

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             mem_wreg_q, mem_wreg_d;
  logic [4:0]       mem_wd_q, mem_wd_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;

  logic [31:0]      quo_q, quo_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic             is_div, is_signed_div, div_by_zero, div_issue, div_last;
  logic             div_load, div_step, div_done, stall;
  logic             wreg_kill;
  logic [4:0]       shamt;
  logic signed [31:0] reg2_s;
  logic signed [63:0] op1_s, op2_s, prod_s;
  logic [63:0]      prod_u;
  logic [32:0]      rem_sh, rem_diff;
  logic [31:0]      logic_res, shift_res, move_res, wdata;

  assign is_div        = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign is_signed_div = (aluop_i == OP_DIV);
  assign div_by_zero   = (reg2_i == 32'd0);
  assign div_issue     = is_div && !div_by_zero;
  assign div_last      = (cnt_q == CNT_W'(DIV_CYCLES - 1));

  // Divider FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divider FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (div_issue) state_d = S_BUSY;
      S_BUSY:  if (div_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Divider FSM: outputs
  always_comb begin
    div_load = 1'b0;
    div_step = 1'b0;
    div_done = 1'b0;
    stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        div_load = div_issue;
        stall    = div_issue;
      end
      S_BUSY: begin
        div_step = 1'b1;
        stall    = 1'b1;
      end
      S_DONE:  div_done = 1'b1;
      default: ;
    endcase
  end

  // Restoring shift-subtract: dividend bits shift out of quo into rem, quotient bits shift in.
  assign rem_sh   = {rem_q, quo_q[31]};
  assign rem_diff = rem_sh - {1'b0, dvs_q};

  always_comb begin
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (div_load) begin
      quo_d     = cond_neg(reg1_i, is_signed_div && reg1_i[31]);
      dvs_d     = cond_neg(reg2_i, is_signed_div && reg2_i[31]);
      rem_d     = 32'd0;
      cnt_d     = '0;
      neg_quo_d = is_signed_div && (reg1_i[31] ^ reg2_i[31]);
      neg_rem_d = is_signed_div && reg1_i[31];
    end else if (div_step) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!rem_diff[32]) begin
        rem_d = rem_diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_sh[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    quo_q     <= quo_d;
    rem_q     <= rem_d;
    dvs_q     <= dvs_d;
    cnt_q     <= cnt_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
  end

  assign op1_s  = {{32{reg1_i[31]}}, reg1_i};
  assign op2_s  = {{32{reg2_i[31]}}, reg2_i};
  assign prod_s = op1_s * op2_s;
  assign prod_u = {32'd0, reg1_i} * {32'd0, reg2_i};

  // HI/LO writes: single-cycle ops only while idle; a finished divide owns the DONE edge.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_done) begin
      hi_d = cond_neg(rem_q, neg_rem_q);
      lo_d = cond_neg(quo_q, neg_quo_q);
    end else if (state_q == S_IDLE) begin
      case (aluop_i)
        OP_MTHI:  hi_d = reg1_i;
        OP_MTLO:  lo_d = reg1_i;
        OP_MULT:  {hi_d, lo_d} = prod_s;
        OP_MULTU: {hi_d, lo_d} = prod_u;
        OP_DIV, OP_DIVU: begin
          if (div_by_zero) begin
            hi_d = reg1_i;
            lo_d = 32'hFFFF_FFFF;
          end
        end
        default: ;
      endcase
    end
  end

  assign shamt  = reg1_i[4:0];
  assign reg2_s = reg2_i;

  always_comb begin
    logic_res = 32'd0;
    case (aluop_i)
      OP_OR:   logic_res = reg1_i | reg2_i;
      OP_AND:  logic_res = reg1_i & reg2_i;
      OP_XOR:  logic_res = reg1_i ^ reg2_i;
      OP_NOR:  logic_res = ~(reg1_i | reg2_i);
      default: logic_res = 32'd0;
    endcase
  end

  always_comb begin
    shift_res = 32'd0;
    case (aluop_i)
      OP_SLL, OP_SLLV: shift_res = reg2_i << shamt;
      OP_SRL, OP_SRLV: shift_res = reg2_i >> shamt;
      OP_SRA, OP_SRAV: shift_res = reg2_s >>> shamt;
      default:         shift_res = 32'd0;
    endcase
  end

  always_comb begin
    move_res = 32'd0;
    case (aluop_i)
      OP_MFHI: move_res = hi_q;
      OP_MFLO: move_res = lo_q;
      default: move_res = 32'd0;
    endcase
  end

  always_comb begin
    wdata = 32'd0;
    case (alusel_i)
      SEL_LOGIC: wdata = logic_res;
      SEL_SHIFT: wdata = shift_res;
      SEL_MOVE:  wdata = move_res;
      default:   wdata = 32'd0;
    endcase
  end

  // Ops that only touch HI/LO never write the register file.
  always_comb begin
    wreg_kill = 1'b0;
    case (aluop_i)
      OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: wreg_kill = 1'b1;
      OP_NOP:  wreg_kill = 1'b0;
      default: wreg_kill = 1'b0;
    endcase
  end

  assign ex_wd_o     = wd_i;
  assign ex_wdata_o  = wdata;
  assign ex_wreg_o   = wreg_i && !wreg_kill && !stall;
  assign stall_req_o = stall;

  always_comb begin
    mem_wreg_d  = ex_wreg_o;
    mem_wd_d    = ex_wd_o;
    mem_wdata_d = ex_wdata_o;
    if (stall) begin
      mem_wreg_d  = 1'b0;
      mem_wd_d    = 5'd0;
      mem_wdata_d = 32'd0;
    end
  end

  // EX/MEM boundary and architectural HI/LO
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      mem_wreg_q  <= 1'b0;
      mem_wd_q    <= 5'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mem_wreg_q  <= mem_wreg_d;
      mem_wd_q    <= mem_wd_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_wreg_o  = mem_wreg_q;
  assign mem_wd_o    = mem_wd_q;
  assign mem_wdata_o = mem_wdata_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: logic, shift, HI/LO moves, multiply, divide timing and
// results, divide-by-zero and reset abandoning a division in flight.
module tb_ex_stage;

  localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27, OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
  localparam logic [7:0] OP_SLLV = 8'h04, OP_SRAV = 8'h07, OP_MFHI = 8'h10, OP_MTHI = 8'h11;
  localparam logic [7:0] OP_MFLO = 8'h12, OP_MTLO = 8'h13, OP_MULT = 8'h18, OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV = 8'h1A, OP_DIVU = 8'h1B;
  localparam logic [2:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_MOVE = 3'd3, SEL_ARITH = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd;
  logic        wreg;
  logic        ex_wreg_o, stall_req_o, mem_wreg_o;
  logic [4:0]  ex_wd_o, mem_wd_o;
  logic [31:0] ex_wdata_o, mem_wdata_o, hi_o, lo_o;

  int checks = 0;
  int failures = 0;

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg),
    .ex_wreg_o(ex_wreg_o), .ex_wd_o(ex_wd_o), .ex_wdata_o(ex_wdata_o),
    .stall_req_o(stall_req_o), .mem_wreg_o(mem_wreg_o), .mem_wd_o(mem_wd_o),
    .mem_wdata_o(mem_wdata_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic we);
    aluop = op; alusel = sel; reg1 = a; reg2 = b; wd = d; wreg = we;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic nop;
    drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  // Issues a divide and follows it through the stall window into DONE and past its edge.
  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int bubbles);
    drive(op, SEL_ARITH, a, b, 5'd6, 1'b1);
    stalls = 0;
    bubbles = 0;
    while (stall_req_o === 1'b1 && stalls < 100) begin
      stalls++;
      tick;
      if (mem_wreg_o === 1'b0 && mem_wd_o === 5'd0 && mem_wdata_o === 32'd0) bubbles++;
    end
    tick;
    nop;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(OP_DIV, SEL_ARITH, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1);
    tick;
    tick;
    checks++; if (hi_o !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", hi_o, 32'd0); end
    checks++; if (lo_o !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", lo_o, 32'd0); end
    checks++; if (mem_wreg_o !== 1'b0) begin failures++; $display("FAIL reset_mem_wreg got=%b exp=0", mem_wreg_o); end
    checks++; if (mem_wdata_o !== 32'd0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata_o); end
    rst = 1'b1;
    nop;
    checks++; if (stall_req_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_req_o); end
    tick;
  endtask

  task automatic test_logic;
    drive(OP_OR, SEL_LOGIC, 32'h0000_F0F0, 32'h0F0F_0000, 5'd7, 1'b1);
    checks++; if (ex_wdata_o !== 32'h0F0F_F0F0) begin failures++; $display("FAIL or_ex got=%h exp=%h", ex_wdata_o, 32'h0F0F_F0F0); end
    checks++; if (ex_wreg_o !== 1'b1 || ex_wd_o !== 5'd7) begin failures++; $display("FAIL or_fwd got=%b/%0d exp=1/7", ex_wreg_o, ex_wd_o); end
    tick;
    checks++; if (mem_wdata_o !== 32'h0F0F_F0F0) begin failures++; $display("FAIL or_mem got=%h exp=%h", mem_wdata_o, 32'h0F0F_F0F0); end
    checks++; if (mem_wreg_o !== 1'b1 || mem_wd_o !== 5'd7) begin failures++; $display("FAIL or_mem_ctl got=%b/%0d exp=1/7", mem_wreg_o, mem_wd_o); end
    drive(OP_NOR, SEL_LOGIC, 32'h0000_F0F0, 32'h0F0F_0000, 5'd7, 1'b1);
    checks++; if (ex_wdata_o !== 32'hF0F0_0F0F) begin failures++; $display("FAIL nor got=%h exp=%h", ex_wdata_o, 32'hF0F0_0F0F); end
    drive(OP_AND, SEL_LOGIC, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd7, 1'b1);
    checks++; if (ex_wdata_o !== 32'h0F00_0F00) begin failures++; $display("FAIL and got=%h exp=%h", ex_wdata_o, 32'h0F00_0F00); end
    drive(OP_XOR, SEL_LOGIC, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd7, 1'b1);
    checks++; if (ex_wdata_o !== 32'hF0F0_F0F0) begin failures++; $display("FAIL xor got=%h exp=%h", ex_wdata_o, 32'hF0F0_F0F0); end
    drive(OP_NOP, SEL_NOP, 32'h1234_5678, 32'h1111_1111, 5'd2, 1'b1);
    checks++; if (ex_wdata_o !== 32'd0 || ex_wreg_o !== 1'b1) begin failures++; $display("FAIL nop got=%h/%b exp=0/1", ex_wdata_o, ex_wreg_o); end
    tick;
  endtask

  task automatic test_shift;
    drive(OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0000, 5'd8, 1'b1);
    checks++; if (ex_wdata_o !== 32'hF800_0000) begin failures++; $display("FAIL sra got=%h exp=%h", ex_wdata_o, 32'hF800_0000); end
    drive(OP_SRL, SEL_SHIFT, 32'd4, 32'h8000_0000, 5'd8, 1'b1);
    checks++; if (ex_wdata_o !== 32'h0800_0000) begin failures++; $display("FAIL srl got=%h exp=%h", ex_wdata_o, 32'h0800_0000); end
    drive(OP_SLL, SEL_SHIFT, 32'd8, 32'h0000_00FF, 5'd8, 1'b1);
    checks++; if (ex_wdata_o !== 32'h0000_FF00) begin failures++; $display("FAIL sll got=%h exp=%h", ex_wdata_o, 32'h0000_FF00); end
    drive(OP_SLLV, SEL_SHIFT, 32'h0000_0024, 32'h0000_00FF, 5'd8, 1'b1);
    checks++; if (ex_wdata_o !== 32'h0000_0FF0) begin failures++; $display("FAIL sllv got=%h exp=%h", ex_wdata_o, 32'h0000_0FF0); end
    drive(OP_SRAV, SEL_SHIFT, 32'd31, 32'h8000_0000, 5'd8, 1'b1);
    checks++; if (ex_wdata_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL srav got=%h exp=%h", ex_wdata_o, 32'hFFFF_FFFF); end
    tick;
  endtask

  task automatic test_mult;
    drive(OP_MULT, SEL_ARITH, 32'hFFFF_FFFF, 32'd2, 5'd4, 1'b1);
    checks++; if (ex_wreg_o !== 1'b0) begin failures++; $display("FAIL mult_wreg got=%b exp=0", ex_wreg_o); end
    tick;
    checks++; if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mult_hilo got=%h_%h exp=ffffffff_fffffffe", hi_o, lo_o); end
    checks++; if (mem_wreg_o !== 1'b0) begin failures++; $display("FAIL mult_mem_wreg got=%b exp=0", mem_wreg_o); end
    drive(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 5'd9, 1'b1);
    checks++; if (ex_wdata_o !== 32'hFFFF_FFFF || ex_wreg_o !== 1'b1) begin failures++; $display("FAIL mfhi got=%h/%b exp=ffffffff/1", ex_wdata_o, ex_wreg_o); end
    tick;
    drive(OP_MULTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd2, 5'd4, 1'b1);
    tick;
    checks++; if (hi_o !== 32'h0000_0001 || lo_o !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hilo got=%h_%h exp=00000001_fffffffe", hi_o, lo_o); end
    drive(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 5'd9, 1'b1);
    checks++; if (ex_wdata_o !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mflo got=%h exp=fffffffe", ex_wdata_o); end
    tick;
  endtask

  task automatic test_move;
    drive(OP_MTHI, SEL_MOVE, 32'h1234_5678, 32'd0, 5'd1, 1'b1);
    checks++; if (ex_wreg_o !== 1'b0) begin failures++; $display("FAIL mthi_wreg got=%b exp=0", ex_wreg_o); end
    tick;
    drive(OP_MTLO, SEL_MOVE, 32'h9ABC_DEF0, 32'd0, 5'd1, 1'b1);
    tick;
    checks++; if (hi_o !== 32'h1234_5678 || lo_o !== 32'h9ABC_DEF0) begin failures++; $display("FAIL mthi_mtlo got=%h_%h exp=12345678_9abcdef0", hi_o, lo_o); end
    nop;
  endtask

  task automatic test_div;
    int stalls, bubbles;
    drive(OP_MTLO, SEL_MOVE, 32'h0000_0055, 32'd0, 5'd1, 1'b1);
    tick;
    do_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, stalls, bubbles);
    checks++; if (stalls !== 33) begin failures++; $display("FAIL div_stall_cycles got=%0d exp=33", stalls); end
    checks++; if (bubbles !== 33) begin failures++; $display("FAIL div_bubbles got=%0d exp=33", bubbles); end
    checks++; if (lo_o !== 32'hFFFF_FFFD || hi_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_signed got=%h_%h exp=ffffffff_fffffffd", hi_o, lo_o); end
    drive(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 5'd9, 1'b1);
    checks++; if (ex_wdata_o !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_mflo got=%h exp=fffffffd", ex_wdata_o); end
    tick;
    do_div(OP_DIVU, 32'd100, 32'd7, stalls, bubbles);
    checks++; if (stalls !== 33) begin failures++; $display("FAIL divu_stall_cycles got=%0d exp=33", stalls); end
    checks++; if (lo_o !== 32'd14 || hi_o !== 32'd2) begin failures++; $display("FAIL divu got=%h_%h exp=00000002_0000000e", hi_o, lo_o); end
  endtask

  task automatic test_div_zero;
    drive(OP_DIVU, SEL_ARITH, 32'd5, 32'd0, 5'd1, 1'b1);
    checks++; if (stall_req_o !== 1'b0) begin failures++; $display("FAIL divz_stall got=%b exp=0", stall_req_o); end
    tick;
    checks++; if (hi_o !== 32'd5 || lo_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divz_hilo got=%h_%h exp=00000005_ffffffff", hi_o, lo_o); end
    checks++; if (mem_wreg_o !== 1'b0) begin failures++; $display("FAIL divz_mem_wreg got=%b exp=0", mem_wreg_o); end
    nop;
    tick;
  endtask

  task automatic test_reset_mid_div;
    int stalls, bubbles;
    drive(OP_DIVU, SEL_ARITH, 32'd100, 32'd7, 5'd1, 1'b1);
    checks++; if (stall_req_o !== 1'b1) begin failures++; $display("FAIL rmd_issue_stall got=%b exp=1", stall_req_o); end
    repeat (10) tick;
    checks++; if (stall_req_o !== 1'b1) begin failures++; $display("FAIL rmd_busy_stall got=%b exp=1", stall_req_o); end
    rst = 1'b0;
    tick;
    rst = 1'b1;
    nop;
    checks++; if (stall_req_o !== 1'b0) begin failures++; $display("FAIL rmd_stall got=%b exp=0", stall_req_o); end
    checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin failures++; $display("FAIL rmd_hilo got=%h_%h exp=0_0", hi_o, lo_o); end
    tick;
    checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin failures++; $display("FAIL rmd_hilo_after got=%h_%h exp=0_0", hi_o, lo_o); end
    do_div(OP_DIVU, 32'd9, 32'd3, stalls, bubbles);
    checks++; if (stalls !== 33) begin failures++; $display("FAIL rmd_div_stall got=%0d exp=33", stalls); end
    checks++; if (lo_o !== 32'd3 || hi_o !== 32'd0) begin failures++; $display("FAIL rmd_divu got=%h_%h exp=00000000_00000003", hi_o, lo_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_logic;
    test_shift;
    test_mult;
    test_move;
    test_div;
    test_div_zero;
    test_reset_mid_div;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline, directly downstream of instruction decode. It consumes the decoded operation (`aluop`/`alusel`), both resolved operands and the destination tag. It computes logic, shift, HI/LO-move, multiply and iterative-divide results and feeds the same-cycle result back to decode for RAW forwarding. It also registers the result toward the memory-access stage and stalls upstream while a division is in flight.

## Interface
- `DIV_CYCLES`, 32: radix-2 iterations per divide; fixed at 32 for 32-bit operands.
- `clk` in 1: sole clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-low.
- `aluop_i` in 8: operation code.
  - OR 8'h25, AND 8'h24, XOR 8'h26, NOR 8'h27
  - SLL 8'h7C, SRL 8'h02, SRA 8'h03, SLLV 8'h04, SRLV 8'h06, SRAV 8'h07
  - MFHI 8'h10, MTHI 8'h11, MFLO 8'h12, MTLO 8'h13
  - MULT 8'h18, MULTU 8'h19, DIV 8'h1A, DIVU 8'h1B
  - NOP 8'h00
- `alusel_i` in 3: result select. NOP 0, LOGIC 1, SHIFT 2, MOVE 3, ARITH 4.
- `reg1_i` in 32: operand 1. For shifts this is the shift amount, bits [4:0] only.
- `reg2_i` in 32: operand 2. For shifts this is the value being shifted.
- `wd_i` in 5: destination register.
- `wreg_i` in 1: register-write enable.
- `ex_wreg_o` out 1: combinational forward to decode, write enable.
- `ex_wd_o` out 5: combinational forward to decode, destination.
- `ex_wdata_o` out 32: combinational forward to decode, result.
- `stall_req_o` out 1: combinational; holds upstream stages while high.
- `mem_wreg_o` out 1: registered to memory-access stage.
- `mem_wd_o` out 5: registered to memory-access stage.
- `mem_wdata_o` out 32: registered to memory-access stage.
- `hi_o` out 32: architectural HI register value.
- `lo_o` out 32: architectural LO register value.

## Operation
- **LOGIC**: bitwise `reg1 op reg2`. NOR gives `~(reg1|reg2)`.
- **SHIFT**: `reg2` shifted by `reg1[4:0]`. SRA/SRAV replicate `reg2[31]`.
- **MOVE**:
  - MFHI/MFLO return HI/LO.
  - MTHI/MTLO write `reg1` to HI/LO at the clock edge, with `wreg` forced 0.
- **MULT/MULTU**: signed/unsigned 32x32 to 64-bit product. `{HI,LO}` is written at the edge. Single cycle, `wreg` forced 0.
- **DIV/DIVU** (`wreg` forced 0): FSM with states IDLE, BUSY, DONE.
  - **IDLE → BUSY**: on a DIV/DIVU opcode with divisor ≠ 0. Operands are latched; signed operands are converted to magnitudes. Iteration counter cleared.
  - **BUSY**: one restoring shift-subtract step per cycle. Moves to DONE after 32 steps.
  - **DONE → IDLE**: unconditional. `{HI,LO} ← {remainder, quotient}`, written at this edge.
    - Signed quotient is negated when operand signs differ.
    - Signed remainder takes the sign of the dividend.
  - **Divisor = 0**: no BUSY. HI ← dividend and LO ← 32'hFFFFFFFF at the issue edge. No stall.
- **NOP / unknown `alusel`**: `wdata` 0; `wreg` passes through `wreg_i`.
- **Forwarding**:
  - `ex_wd_o = wd_i`.
  - `ex_wreg_o = wreg_i` except where forced 0 above. Also forced 0 while `stall_req_o` = 1.
- **MEM register**:
  - Captures the forward outputs each edge.
  - Loads a bubble (`wreg` 0, `wd` 0, `wdata` 0) on every edge where `stall_req_o` = 1.
- **HI/LO read-after-write**: HI/LO are written in this stage, so an MFHI in the cycle after MULT sees the new value. No hazard logic is needed.

## Timing
- **Reset** (`rst` = 0 at an edge):
  - FSM → IDLE; HI, LO, and all `mem_*` outputs → 0.
  - `stall_req_o` = 0 from the next cycle.
  - A division in progress is abandoned; HI/LO are not written.
- **Single-cycle ops**: forward outputs valid in the same cycle; `mem_*` valid one edge later.
- **`stall_req_o`**: = 1 when (IDLE and DIV/DIVU issued with divisor ≠ 0) or state = BUSY. It is 0 in DONE.
- **Divide issued in cycle T**:
  - Stall high for T..T+32 (33 cycles).
  - DONE in T+33, where stall is low, the pipeline advances, and HI/LO update at the end of T+33.
  - Minimum latency to a dependent MFLO issuing: T+34.
- **Held inputs**: upstream holds `aluop_i`/operands stable while stalled. The FSM ignores `aluop_i` in BUSY and DONE, so the held DIV never re-issues.
- **MTHI/MTLO in the cycle before a DIV**: the DIV result overwrites it, in program order.

## Test plan
- **Reset**: `rst` = 0 for 2 cycles with DIV applied → `hi_o`=`lo_o`=0, `stall_req_o`=0, `mem_wreg_o`=0.
- **Logic and shift**:
  - OR 32'h0000_F0F0 | 32'h0F0F_0000 → `ex_wdata_o`=32'h0F0F_F0F0 same cycle, `mem_wdata_o` next cycle.
  - SRA with `reg1`=4, `reg2`=32'h8000_0000 → 32'hF800_0000.
- **MULT then MFHI/MFLO**: MULT 32'hFFFF_FFFF × 2 (signed) → HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFE. MFHI next cycle returns 32'hFFFF_FFFF.
- **Signed DIV** (−7)/2 → stall exactly 33 cycles with 33 bubbles on `mem_wreg_o`, then LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. DIVU 100/7 → LO=14, HI=2.
- **Divide by zero**: DIVU 5/0 → no stall, HI=5, LO=32'hFFFF_FFFF after one edge.
- **Reset mid-division**: `rst` low in iteration 10 → IDLE, stall low next cycle, HI/LO=0. A following DIVU 9/3 gives LO=3, HI=0.
